// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator running on CLOCK_50.
// A pixel-enable divider steps the h/v raster counters. Stage 1 registers the
// coordinates and strobes. Stage 2 registers sync and colour, so sync and RGB
// leave together and the pixel source gets one full cycle to answer x/y.
// Optional feature macro: VGA_TESTPATTERN_EN (built-in 8-bar colour pattern on pat_sel).
module vga_timing_gen #(
    parameter int COLOR_W = 4,
    parameter int XY_W    = 10,
    parameter int DIV     = 2,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [COLOR_W-1:0] pix_r,
    input  logic [COLOR_W-1:0] pix_g,
    input  logic [COLOR_W-1:0] pix_b,
    input  logic               pat_sel,
    output logic               pix_en,
    output logic [XY_W-1:0]    xposition,
    output logic [XY_W-1:0]    yposition,
    output logic               on,
    output logic               line_start,
    output logic               frame_start,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic [COLOR_W-1:0] VGA_R,
    output logic [COLOR_W-1:0] VGA_G,
    output logic [COLOR_W-1:0] VGA_B
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(DIV);

    // divider and raster counters
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [XY_W-1:0]  h_q, h_d, v_q, v_d;
    logic             pix_en_q, tick;

    // stage 1
    logic [XY_W-1:0]  xpos_q, ypos_q;
    logic             on_q, on_d, ls_q, ls_d, fs_q, fs_d;

    // stage 2
    logic             hs_act_q, hs_act_d, vs_act_q, vs_act_d;
    logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic [COLOR_W-1:0] src_r, src_g, src_b;

    // divider wrap and raster advance; v only moves when h wraps
    always_comb begin
        tick      = (div_cnt_q == DIV_W'(DIV - 1));
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        h_d       = h_q;
        v_d       = v_q;
        if (tick) begin
            if (h_q == XY_W'(H_TOTAL - 1)) begin
                h_d = '0;
                v_d = (v_q == XY_W'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // counter state; pix_en is registered so it is high the cycle h has just stepped
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            div_cnt_q <= '0;
            h_q       <= '0;
            v_q       <= '0;
            pix_en_q  <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            h_q       <= h_d;
            v_q       <= v_d;
            pix_en_q  <= tick;
        end
    end

    // stage-1 decode; gating with pix_en_q keeps the post-reset (0,0) from strobing
    always_comb begin
        on_d = (h_q < XY_W'(H_VIS)) && (v_q < XY_W'(V_VIS));
        ls_d = pix_en_q && (h_q == '0);
        fs_d = ls_d && (v_q == '0);
    end

    // stage-1 registers: coordinates, visible flag, line/frame strobes
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            xpos_q <= '0;
            ypos_q <= '0;
            on_q   <= 1'b0;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            xpos_q <= h_q;
            ypos_q <= v_q;
            on_q   <= on_d;
            ls_q   <= ls_d;
            fs_q   <= fs_d;
        end
    end

`ifdef VGA_TESTPATTERN_EN
    logic [XY_W-1:0] bar;
    logic [2:0]      idx;

    // colour bars: brightest (white) at the left, black at the right
    always_comb begin
        bar   = xpos_q / XY_W'(H_VIS / 8);
        idx   = 3'd7 - 3'(bar);
        src_r = pat_sel ? {COLOR_W{idx[2]}} : pix_r;
        src_g = pat_sel ? {COLOR_W{idx[1]}} : pix_g;
        src_b = pat_sel ? {COLOR_W{idx[0]}} : pix_b;
    end
`else
    logic pat_sel_unused;
    assign pat_sel_unused = pat_sel;
    assign src_r = pix_r;
    assign src_g = pix_g;
    assign src_b = pix_b;
`endif

    // stage-2 decode from the stage-1 coordinates; VS follows y so it moves on h wrap only
    always_comb begin
        hs_act_d = (xpos_q >= XY_W'(H_VIS + H_FP)) && (xpos_q < XY_W'(H_VIS + H_FP + H_SYNC));
        vs_act_d = (ypos_q >= XY_W'(V_VIS + V_FP)) && (ypos_q < XY_W'(V_VIS + V_FP + V_SYNC));
        r_d      = on_q ? src_r : '0;
        g_d      = on_q ? src_g : '0;
        b_d      = on_q ? src_b : '0;
    end

    // stage-2 registers: sync activity and blanked colour
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            hs_act_q <= 1'b0;
            vs_act_q <= 1'b0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
        end else begin
            hs_act_q <= hs_act_d;
            vs_act_q <= vs_act_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
        end
    end

    assign pix_en      = pix_en_q;
    assign xposition   = xpos_q;
    assign yposition   = ypos_q;
    assign on          = on_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign VGA_HS      = HS_POL ? hs_act_q : ~hs_act_q;
    assign VGA_VS      = VS_POL ? vs_act_q : ~vs_act_q;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;

endmodule
